sipo_load_ctrl: RTL
===================

// Module: sipo_load_ctrl
//
// PURPOSE
// Serial-in/parallel-out loader. It sits directly upstream of the enabled 4-bit
// storage flop and feeds it. A frame of WIDTH serial bits is shifted in after a
// start strobe. The assembled word is presented on d_out together with a
// one-cycle load strobe, which drives the downstream register's en and d.
// A small FSM sequences each frame; frames may run back-to-back.
//
// PARAMETERS
// WIDTH      4   data bits per frame; legal range 2..32
// MSB_FIRST  1   1: first received bit lands in d_out[WIDTH-1]; 0: first bit lands in d_out[0]
//
// PORTS
// clk      in   1      rising-edge clock
// reset    in   1      synchronous reset, active-high
// start    in   1      frame start strobe; sampled in IDLE and DONE only
// sin      in   1      serial data; sampled only in SHIFT (and PARITY)
// d_out    out  WIDTH  last complete word; drives downstream d
// load     out  1      one-cycle strobe, d_out is new; drives downstream en
// busy     out  1      frame in progress (SHIFT/PARITY)
// par_err  out  1      parity failure pulse; present only with PARITY_CHECK_EN
//
// BEHAVIOUR
// - Reset: one clock and one reset. Reset is synchronous and active-high.
//   It takes effect on the rising clk edge where reset=1 and overrides all other inputs.
//   After that edge: state=IDLE, shift reg=0, bit count=0, d_out=0, load=0, busy=0, par_err=0.
// - States: IDLE, SHIFT, [PARITY], DONE. All outputs are registered or state-decoded (no comb path from inputs).
// - IDLE: start=1 -> SHIFT, count=0. sin is ignored, including on the start edge.
// - SHIFT: each edge samples sin and increments count.
//   - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}. MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
//   - start is ignored in SHIFT.
//   - On the WIDTH-th sample: go to DONE (PARITY if the macro is enabled); count wraps to 0.
// - DONE: lasts exactly 1 cycle.
//   - d_out is updated from the final shift value on the edge that enters DONE.
//   - load=1 only while in DONE.
//   - Next state: start=1 -> SHIFT (back-to-back frame, no gap); otherwise IDLE.
// - busy=1 in SHIFT/PARITY, 0 in IDLE/DONE.
// - Latency: start seen at edge N; data bits sampled at edges N+1..N+WIDTH.
//   load is high from edge N+WIDTH to N+WIDTH+1. The downstream flop captures at N+WIDTH+1.
// - d_out holds its value between frames. It changes only on DONE entry or reset.
// - Reset mid-frame: the frame is aborted, no load is issued, and d_out is cleared to 0.
// - Reset in DONE: load drops on that edge.
// - start and reset on the same edge: reset wins.
//
// CONFIGURATION
// Macro PARITY_CHECK_EN:
// - Defined:
//   - One extra bit (the parity bit) follows the data. It is sampled in state PARITY; frame length is WIDTH+1.
//   - Even parity over data+parity bit.
//   - Parity OK -> DONE as normal.
//   - Parity bad -> IDLE directly: no load, d_out unchanged, par_err=1 for exactly that one cycle.
//   - start is not accepted on the same edge as a parity error.
// - Not defined: no PARITY state, no par_err port, frame length is WIDTH.
//
// TESTING (WIDTH=4, MSB_FIRST=1 unless stated)
// 1. reset=1 for 2 cycles with start=1 and sin toggling
//    -> d_out=4'b0000, load=0, busy=0 throughout.
// 2. start at edge N; sin=0,1,1,0 at edges N+1..N+4
//    -> busy=1 for 4 cycles; load=1 for exactly 1 cycle after edge N+4; d_out=4'b0110.
//    Repeat with MSB_FIRST=0 -> d_out=4'b0110 reversed = 4'b0110 for this pattern.
//    Also sin=1,0,0,0 -> d_out=4'b0001.
// 3. start held high during the DONE cycle, then sin=1,1,0,0
//    -> second load exactly 5 cycles after the first; d_out=4'b1100; no IDLE cycle between frames.
// 4. start pulsed mid-SHIFT, and sin toggled while in IDLE
//    -> frame length unchanged; d_out and load unaffected outside DONE.
// 5. reset asserted after 2 data bits
//    -> next edge: IDLE, d_out=0, busy=0; no load pulse at any time.
// 6. PARITY_CHECK_EN defined:
//    - 0110 + parity bit 0 -> load pulse, d_out=4'b0110, par_err=0.
//    - Then 1100 + parity bit 1 -> par_err=1 for 1 cycle, load=0, d_out stays 4'b0110.

Source files
------------

// File: rtl/sipo_load_ctrl_if.sv
// Handshake/bus bundle for the serial-in/parallel-out loader.
//   start   : frame start strobe (upstream -> loader)
//   sin     : serial data bit    (upstream -> loader)
//   d_out   : last complete word (loader -> downstream d)
//   load    : one-cycle new-word strobe (loader -> downstream en)
//   busy    : frame in progress
//   par_err : parity failure pulse (only when PARITY_CHECK_EN is defined)
interface sipo_load_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             sin;
    logic [WIDTH-1:0] d_out;
    logic             load;
    logic             busy;
`ifdef PARITY_CHECK_EN
    logic             par_err;

    modport master (output start, output sin, input d_out, input load, input busy, input par_err);
    modport slave  (input start, input sin, output d_out, output load, output busy, output par_err);
`else
    modport master (output start, output sin, input d_out, input load, input busy);
    modport slave  (input start, input sin, output d_out, output load, output busy);
`endif
endinterface

// File: rtl/sipo_load_ctrl.sv
// Serial-in/parallel-out loader feeding an enabled storage register.
// A start strobe opens a frame of WIDTH serial bits; the assembled word is
// published on d_out with a one-cycle load strobe. Frames may run back-to-back.
// Optional feature macro: PARITY_CHECK_EN (adds an even-parity bit per frame
// and a par_err pulse; a bad frame returns to IDLE without loading).
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : sipo_load_ctrl_if.slave (start, sin in; d_out, load, busy[, par_err] out)
module sipo_load_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    sipo_load_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] d_out_q;
    logic             load_q;
    logic             busy_q;
    logic             last_bit_c;
`ifdef PARITY_CHECK_EN
    logic             par_err_q;
    logic             parity_ok_c;
`endif

    // Shift register next value with the incoming serial bit
    always_comb begin
        sr_d = sr_q;
        if (MSB_FIRST) begin
            sr_d = {sr_q[WIDTH-2:0], bus.sin};
        end else begin
            sr_d = {bus.sin, sr_q[WIDTH-1:1]};
        end
    end

    assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef PARITY_CHECK_EN
    // Even parity across the data word plus the parity bit
    assign parity_ok_c = ~((^sr_q) ^ bus.sin);
`endif

    // Frame sequencer; load/busy/par_err are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            d_out_q   <= '0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            load_q    <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    sr_q <= sr_d;
                    if (last_bit_c) begin
                        cnt_q <= '0;
`ifdef PARITY_CHECK_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_DONE;
                        d_out_q <= sr_d;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                S_PARITY: begin
                    busy_q <= 1'b0;
                    if (parity_ok_c) begin
                        state_q <= S_DONE;
                        d_out_q <= sr_q;
                        load_q  <= 1'b1;
                    end else begin
                        // Bad frame is dropped; start is not honoured on this edge
                        state_q   <= S_IDLE;
                        par_err_q <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.start) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.d_out   = d_out_q;
    assign bus.load    = load_q;
    assign bus.busy    = busy_q;
`ifdef PARITY_CHECK_EN
    assign bus.par_err = par_err_q;
`endif

endmodule
